// File: rtl/instruction_fetch_pkg.sv
// Shared constants and types for the fetch stage.
// Holds reset PC, PC step, bubble word and fetch state encoding.
package instruction_fetch_pkg;

  localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
  localparam logic [31:0] PC_STEP_DEF  = 32'd4;
  localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HALTED = 2'd1,
    FAULT  = 2'd2
  } fetch_state_t;

  function automatic logic misaligned(input logic [31:0] a);
    return a[1:0] != 2'b00;
  endfunction

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/instruction_fetch_id_reg.sv
// IF/ID pipeline register: instrD, pcD, bubbleD with hold/load/insert.
// Ports: clk, reset (async low), load, insert, instrIn, pcIn -> instrD, pcD, bubbleD.
module if_id_reg
  import instruction_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        insert,
  input  logic [31:0] instrIn,
  input  logic [31:0] pcIn,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        bubbleD
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      instrD  <= BUBBLE_INSTR;
      pcD     <= 32'h0;
      bubbleD <= 1'b1;
    end else if (insert) begin
      instrD  <= BUBBLE_INSTR;
      pcD     <= pcIn;
      bubbleD <= 1'b1;
    end else if (load) begin
      instrD  <= instrIn;
      pcD     <= pcIn;
      bubbleD <= 1'b0;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage + IF/ID register: PC, delay-slot redirect, stall, halt.
// Ports: imem req/addr/data/ready, stallD, redirect(+Target), halt ->
// instrD, pcD, bubbleD, fetchFault. Option: INSTRUCTION_FETCH_ALIGN_CHECK_EN.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEF
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imemAddr,
  output logic        imemReq,
  input  logic [31:0] imemData,
  input  logic        imemReady,
  input  logic        stallD,
  input  logic        redirect,
  input  logic [31:0] redirectTarget,
  input  logic        halt,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic        bubbleD,
  output logic        fetchFault
);

  fetch_state_t state, stateNext;
  logic [31:0]  pcF, pcNext;
  logic         pendingValid;
  logic [31:0]  pendingTarget;
  logic         run, accept, useTarget;
  logic [31:0]  target;
  logic         idLoad, idInsert;
  logic [31:0]  idPc;

  assign run       = (state == RUN);
  assign accept    = run && imemReady && !stallD;
  // A pending target always outranks a fresh redirect.
  assign useTarget = pendingValid || redirect;
  assign target    = pendingValid ? pendingTarget : redirectTarget;

`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
  logic        badTarget;
  logic        faultQ;
  logic [31:0] faultPC;

  assign badTarget = accept && !halt && useTarget && misaligned(target);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      faultQ  <= 1'b0;
      faultPC <= 32'h0;
    end else if (badTarget) begin
      faultQ  <= 1'b1;
      faultPC <= target;
    end
  end

  assign fetchFault = faultQ;
`else
  assign fetchFault = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    case (state)
      RUN: begin
        if (halt) stateNext = HALTED;
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
        else if (badTarget) stateNext = FAULT;
`endif
      end
      HALTED:  stateNext = HALTED;
      FAULT:   stateNext = FAULT;
      default: stateNext = RUN;
    endcase
  end

  always_comb begin
    imemReq = 1'b0;
    if (state == RUN) imemReq = 1'b1;
  end

  assign imemAddr = pcF;

  always_comb begin
    pcNext = pcF;
    if (accept && !halt) begin
      if (useTarget) begin
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
        if (!misaligned(target)) pcNext = target;
`else
        pcNext = word_align(target);
`endif
      end else begin
        pcNext = pcF + PC_STEP;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcF           <= RESET_PC;
      pendingValid  <= 1'b0;
      pendingTarget <= 32'h0;
    end else begin
      pcF <= pcNext;
      if (halt) begin
        pendingValid <= 1'b0;
      end else if (accept) begin
        pendingValid <= 1'b0;
      end else if (run && !stallD && redirect && !pendingValid) begin
        // Memory wait: the delay slot is still owed, park the target.
        pendingValid  <= 1'b1;
        pendingTarget <= redirectTarget;
      end
    end
  end

  // Halt and post-fault bubbles keep pcD; wait-state bubbles carry pcF.
  always_comb begin
    idLoad   = accept && !halt;
    idInsert = 1'b0;
    idPc     = pcF;
    if (halt) begin
      idInsert = 1'b1;
      idPc     = pcD;
    end else if (state == FAULT) begin
      idInsert = !stallD;
      idPc     = pcD;
    end else if (run && !stallD && !imemReady) begin
      idInsert = 1'b1;
    end
  end

  if_id_reg u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load    (idLoad),
    .insert  (idInsert),
    .instrIn (imemData),
    .pcIn    (idPc),
    .instrD  (instrD),
    .pcD     (pcD),
    .bubbleD (bubbleD)
  );

  a_no_redirect_while_pending : assert property (
    @(posedge clk) disable iff (!reset)
    !(run && !stallD && redirect && pendingValid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch.
// Memory model answers every address; expected IF/ID words queued on accept.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imemAddr;
  logic        imemReq;
  logic [31:0] imemData;
  logic        imemReady;
  logic        stallD;
  logic        redirect;
  logic [31:0] redirectTarget;
  logic        halt;
  logic [31:0] instrD;
  logic [31:0] pcD;
  logic        bubbleD;
  logic        fetchFault;

  always #5 clk = ~clk;

  instruction_fetch dut (
    .clk            (clk),
    .reset          (reset),
    .imemAddr       (imemAddr),
    .imemReq        (imemReq),
    .imemData       (imemData),
    .imemReady      (imemReady),
    .stallD         (stallD),
    .redirect       (redirect),
    .redirectTarget (redirectTarget),
    .halt           (halt),
    .instrD         (instrD),
    .pcD            (pcD),
    .bubbleD        (bubbleD),
    .fetchFault     (fetchFault)
  );

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0000_3004) return 32'h3C01_0001;
    return a ^ 32'h8C00_0000;
  endfunction

  assign imemData = mem(imemAddr);

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
  } item_t;

  item_t       sb[$];
  int          nChecks = 0;
  int          nFails  = 0;

  logic [31:0] mPc, mPendT, eInstr, ePc;
  logic        mPend, eBub, mFault;
  int          mState;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    imemReady = 1'b0; stallD = 1'b0; redirect = 1'b0;
    redirectTarget = 32'h0; halt = 1'b0;
    mPc = 32'h3000; mPend = 1'b0; mPendT = 32'h0;
    eInstr = 32'h0; ePc = 32'h0; eBub = 1'b1; mFault = 1'b0; mState = 0;
    sb.delete();
    #1;
    check("rst_pcF", imemAddr, 32'h3000);
    check("rst_instrD", instrD, 32'h0);
    check("rst_pcD", pcD, 32'h0);
    check("rst_bubbleD", {31'h0, bubbleD}, 32'h1);
    check("rst_fetchFault", {31'h0, fetchFault}, 32'h0);
    check("rst_imemReq", {31'h0, imemReq}, 32'h1);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic step(input logic rdy, input logic st, input logic rd,
                      input logic [31:0] tgt, input logic hl);
    logic        push;
    logic [31:0] t;
    item_t       it;
    imemReady = rdy; stallD = st; redirect = rd;
    redirectTarget = tgt; halt = hl;
    #1;
    check("imemAddr", imemAddr, mPc);
    check("imemReq", {31'h0, imemReq}, {31'h0, (mState == 0)});
    push = 1'b0;
    if (hl) begin
      if (mState == 0) mState = 1;
      eBub = 1'b1; eInstr = 32'h0; mPend = 1'b0;
    end else if (mState == 2) begin
      if (!st) begin eBub = 1'b1; eInstr = 32'h0; end
    end else if (mState == 1 || st) begin
    end else if (rdy) begin
      it.instr = mem(mPc); it.pc = mPc;
      sb.push_back(it); push = 1'b1;
      eInstr = it.instr; ePc = mPc; eBub = 1'b0;
      if (mPend || rd) begin
        t = mPend ? mPendT : tgt;
        mPend = 1'b0;
`ifdef INSTRUCTION_FETCH_ALIGN_CHECK_EN
        if (t[1:0] != 2'b00) begin mState = 2; mFault = 1'b1; end
        else mPc = t;
`else
        mPc = {t[31:2], 2'b00};
`endif
      end else begin
        mPc = mPc + 32'd4;
      end
    end else begin
      eInstr = 32'h0; ePc = mPc; eBub = 1'b1;
      if (rd && !mPend) begin mPend = 1'b1; mPendT = tgt; end
    end
    @(posedge clk);
    #1;
    if (push && sb.size() > 0) begin
      it = sb.pop_front();
      check("instrD", instrD, it.instr);
      check("pcD", pcD, it.pc);
    end else begin
      check("instrD_hold", instrD, eInstr);
      check("pcD_hold", pcD, ePc);
    end
    check("bubbleD", {31'h0, bubbleD}, {31'h0, eBub});
    check("fetchFault", {31'h0, fetchFault}, {31'h0, mFault});
  endtask

  logic        rRdy, rSt, rRd;
  logic [31:0] rTgt;

  initial begin
    reset = 1'b0;
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    repeat (3) step(1, 1, 1, 32'h3F00, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 32'h3100, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 32'h3200, 0);
    step(0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 32'hFFFF_FFF8, 0);
    repeat (4) step(1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    repeat (20) begin
      rRdy = 1'($urandom_range(0, 1));
      rSt  = 1'($urandom_range(0, 1));
      step(rRdy, rSt, 1'b1, 32'h4000, 0);
    end
    do_reset();
    repeat (3) step(1, 0, 0, 0, 0);
    repeat (150) begin
      rRdy = ($urandom_range(0, 3) != 0);
      rSt  = ($urandom_range(0, 4) == 0);
      rRd  = !mPend && ($urandom_range(0, 5) == 0);
      rTgt = $urandom() & 32'h0000_FFFC;
      step(rRdy, rSt, rRd, rTgt, 0);
    end
    do_reset();
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 32'h3102, 0);
    repeat (4) step(1, 0, 0, 0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFails);
    $finish;
  end

endmodule
